// File: rtl/periph_bus_arbiter_if.sv
// Peripheral register bus interface (PicoRV32-style valid/ready handshake).
//   valid : request from the bus master
//   addr  : byte address
//   wdata : write data
//   wstrb : byte strobes, 0 = read
//   ready : one-cycle completion pulse from the slave
//   rdata : read data, meaningful while ready is high
// Modports: master (drives the request), slave (answers it).
interface periph_bus_arbiter_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              ready;
    logic [DATA_W-1:0] rdata;

    modport master (output valid, addr, wdata, wstrb, input  ready, rdata);
    modport slave  (input  valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/periph_bus_arbiter.sv
// Two-master / one-slave arbiter for the peripheral register bus.
// Round-robin grant, locked for the whole transfer, one forced idle cycle
// between transfers. Optional watchdog (macro PERIPH_ARB_WATCHDOG_EN)
// terminates a transfer the slave never acknowledges.
// Ports:
//   cpu_clk    : clock
//   reset      : synchronous, active-high reset
//   m0, m1     : master-side buses (CPU, debug/DMA engine)
//   s          : slave-side bus
//   err_clr    : clears err_flag
//   err_flag   : sticky watchdog-fired flag
//   err_master : master that was granted when the watchdog last fired
module periph_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                   cpu_clk,
    input  logic                   reset,
    periph_bus_arbiter_if.slave    m0,
    periph_bus_arbiter_if.slave    m1,
    periph_bus_arbiter_if.master   s,
    input  logic                   err_clr,
    output logic                   err_flag,
    output logic                   err_master
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_last_grant;
    logic [31:0] r_m0_rdata;
    logic [31:0] r_m1_rdata;

    logic        w_active;
    logic        w_timeout;
    logic        w_done;
    logic        w_m0_ready;
    logic        w_m1_ready;
    logic [31:0] w_dlv_rdata;

    // last_grant equals the owner during GNTx, so it alone steers the mux
    assign w_active = (r_state != IDLE);
    assign w_done   = w_active && (s.ready || w_timeout);

    // s_ready has priority: w_timeout only asserts while s_ready is low
    assign w_dlv_rdata = w_timeout ? ERR_RDATA : s.rdata;

    assign s.valid = w_active;
    assign s.addr  = r_last_grant ? m1.addr  : m0.addr;
    assign s.wdata = r_last_grant ? m1.wdata : m0.wdata;
    assign s.wstrb = w_active ? (r_last_grant ? m1.wstrb : m0.wstrb) : 4'b0000;

    assign w_m0_ready = w_done && (r_state == GNT0);
    assign w_m1_ready = w_done && (r_state == GNT1);

    assign m0.ready = w_m0_ready;
    assign m1.ready = w_m1_ready;
    assign m0.rdata = w_m0_ready ? w_dlv_rdata : r_m0_rdata;
    assign m1.rdata = w_m1_ready ? w_dlv_rdata : r_m1_rdata;

    // Grant FSM and delivered-data capture
    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_m0_rdata   <= 32'h0;
            r_m1_rdata   <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (m0.valid && (!m1.valid || r_last_grant)) begin
                        r_state      <= GNT0;
                        r_last_grant <= 1'b0;
                    end else if (m1.valid) begin
                        r_state      <= GNT1;
                        r_last_grant <= 1'b1;
                    end
                end
                GNT0, GNT1: begin
                    if (w_done) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_m0_ready) begin
                r_m0_rdata <= w_dlv_rdata;
            end
            if (w_m1_ready) begin
                r_m1_rdata <= w_dlv_rdata;
            end
        end
    end

`ifdef PERIPH_ARB_WATCHDOG_EN
    localparam int unsigned WD_W = 16;

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_err_flag;
    logic            r_err_master;

    assign w_timeout  = w_active && !s.ready && (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign err_flag   = r_err_flag;
    assign err_master = r_err_master;

    // Stall counter (cleared in IDLE, so every grant starts from 0) and sticky error
    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            r_wd_cnt     <= '0;
            r_err_flag   <= 1'b0;
            r_err_master <= 1'b0;
        end else begin
            if (!w_active) begin
                r_wd_cnt <= '0;
            end else if (!s.ready) begin
                r_wd_cnt <= r_wd_cnt + WD_W'(1);
            end

            // a firing watchdog beats a simultaneous clear
            if (w_timeout) begin
                r_err_flag   <= 1'b1;
                r_err_master <= (r_state == GNT1);
            end else if (err_clr) begin
                r_err_flag <= 1'b0;
            end
        end
    end
`else
    logic w_unused;

    assign w_timeout  = 1'b0;
    assign err_flag   = 1'b0;
    assign err_master = 1'b0;
    assign w_unused   = ^{err_clr, 16'(TIMEOUT_CYCLES)};
`endif

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Self-checking bench for periph_bus_arbiter: directed scenarios plus a
// randomized run checked against a bus-ownership reference model.
module tb_periph_bus_arbiter;

    logic cpu_clk = 1'b0;
    logic reset;
    logic err_clr;
    logic err_flag;
    logic err_master;

    int n_tests = 0;
    int n_fail  = 0;

    periph_bus_arbiter_if bus_m0();
    periph_bus_arbiter_if bus_m1();
    periph_bus_arbiter_if bus_s();

    periph_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .cpu_clk    (cpu_clk),
        .reset      (reset),
        .m0         (bus_m0),
        .m1         (bus_m1),
        .s          (bus_s),
        .err_clr    (err_clr),
        .err_flag   (err_flag),
        .err_master (err_master)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic cyc();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge cpu_clk);
    endtask

    task automatic idle_bus();
        bus_m0.valid = 1'b0;
        bus_m1.valid = 1'b0;
        bus_s.ready  = 1'b0;
        err_clr      = 1'b0;
    endtask

    // Leaves the bench in the first cycle after reset, reset low
    task automatic do_reset();
        reset = 1'b1;
        idle_bus();
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_bus();
        bus_m0.addr = 32'h0; bus_m0.wdata = 32'h0; bus_m0.wstrb = 4'hF;
        bus_m1.addr = 32'h0; bus_m1.wdata = 32'h0; bus_m1.wstrb = 4'hF;
        bus_s.rdata = 32'h0;
        cyc(); cyc(); sample();
        n_tests++;
        if ({bus_s.valid, bus_m0.ready, bus_m1.ready} !== 3'b000) begin
            n_fail++; $display("FAIL reset_valid_ready got %b want 000", {bus_s.valid, bus_m0.ready, bus_m1.ready});
        end
        n_tests++;
        if (bus_s.wstrb !== 4'h0) begin
            n_fail++; $display("FAIL reset_wstrb got %h want 0", bus_s.wstrb);
        end
        n_tests++;
        if ({bus_m0.rdata, bus_m1.rdata} !== 64'h0) begin
            n_fail++; $display("FAIL reset_rdata got %h want 0", {bus_m0.rdata, bus_m1.rdata});
        end
        n_tests++;
        if ({err_flag, err_master} !== 2'b00) begin
            n_fail++; $display("FAIL reset_err got %b want 00", {err_flag, err_master});
        end
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        bus_m0.valid = 1'b1; bus_m0.addr = 32'h0000_0010; bus_m0.wstrb = 4'h0; bus_m0.wdata = $urandom;
        sample();
        n_tests++;
        if (bus_s.valid !== 1'b0) begin
            n_fail++; $display("FAIL single_req_cycle s_valid got %b want 0", bus_s.valid);
        end
        cyc(); sample();
        n_tests++;
        if ({bus_s.valid, bus_m0.ready} !== 2'b10 || bus_s.addr !== 32'h0000_0010) begin
            n_fail++; $display("FAIL single_grant got valid/ready %b addr %h want 10 addr 00000010",
                               {bus_s.valid, bus_m0.ready}, bus_s.addr);
        end
        cyc(); bus_s.ready = 1'b1; bus_s.rdata = 32'h0000_1234; sample();
        n_tests++;
        if ({bus_m0.ready, bus_m1.ready} !== 2'b10 || bus_m0.rdata !== 32'h0000_1234) begin
            n_fail++; $display("FAIL single_done got m0/m1 ready %b rdata %h want 10 00001234",
                               {bus_m0.ready, bus_m1.ready}, bus_m0.rdata);
        end
        cyc(); bus_s.ready = 1'b0; bus_m0.valid = 1'b0; bus_s.rdata = $urandom; sample();
        n_tests++;
        if ({bus_s.valid, bus_m0.ready} !== 2'b00 || bus_m0.rdata !== 32'h0000_1234) begin
            n_fail++; $display("FAIL single_after got valid/ready %b rdata %h want 00 00001234",
                               {bus_s.valid, bus_m0.ready}, bus_m0.rdata);
        end
        cyc();
    endtask

    // Both request right after reset; each re-requests once. Order must be 0,1,0,1.
    task automatic test_contention();
        logic [31:0] a [4];
        logic [31:0] d [4];
        logic [31:0] prev_rd [2];
        int exp_m;
        for (int i = 0; i < 4; i++) begin
            a[i] = $urandom; d[i] = $urandom;
        end
        prev_rd[0] = 32'h0; prev_rd[1] = 32'h0;
        do_reset();
        bus_m0.valid = 1'b1; bus_m0.addr = a[0]; bus_m0.wstrb = 4'h0;
        bus_m1.valid = 1'b1; bus_m1.addr = a[1]; bus_m1.wstrb = 4'h0;
        for (int k = 0; k < 4; k++) begin
            exp_m = k % 2;
            sample();
            n_tests++;
            if (bus_s.valid !== 1'b0) begin
                n_fail++; $display("FAIL contention_gap[%0d] s_valid got %b want 0", k, bus_s.valid);
            end
            cyc(); sample();
            n_tests++;
            if (bus_s.valid !== 1'b1 || bus_s.addr !== a[k]) begin
                n_fail++; $display("FAIL contention_grant[%0d] got valid %b addr %h want 1 %h", k, bus_s.valid, bus_s.addr, a[k]);
            end
            cyc(); bus_s.ready = 1'b1; bus_s.rdata = d[k]; sample();
            n_tests++;
            if ({bus_m1.ready, bus_m0.ready} !== ((exp_m == 1) ? 2'b10 : 2'b01)) begin
                n_fail++; $display("FAIL contention_order[%0d] got m1/m0 ready %b want master %0d", k, {bus_m1.ready, bus_m0.ready}, exp_m);
            end
            n_tests++;
            if (((exp_m == 1) ? bus_m1.rdata : bus_m0.rdata) !== d[k] ||
                ((exp_m == 1) ? bus_m0.rdata : bus_m1.rdata) !== prev_rd[1 - exp_m]) begin
                n_fail++; $display("FAIL contention_rdata[%0d] got m0 %h m1 %h want owner %h other %h",
                                   k, bus_m0.rdata, bus_m1.rdata, d[k], prev_rd[1 - exp_m]);
            end
            prev_rd[exp_m] = d[k];
            cyc(); bus_s.ready = 1'b0;
            if (k < 2) begin
                if (exp_m == 0) bus_m0.addr = a[k + 2];
                else            bus_m1.addr = a[k + 2];
            end else begin
                if (exp_m == 0) bus_m0.valid = 1'b0;
                else            bus_m1.valid = 1'b0;
            end
        end
        sample();
        n_tests++;
        if (bus_s.valid !== 1'b0) begin
            n_fail++; $display("FAIL contention_end s_valid got %b want 0", bus_s.valid);
        end
        cyc();
    endtask

    task automatic test_write_lock();
        idle_bus();
        bus_m1.valid = 1'b1; bus_m1.addr = 32'h1000_0004; bus_m1.wdata = 32'hA5A5_5A5A; bus_m1.wstrb = 4'b0011;
        sample();
        cyc();
        for (int i = 0; i < 4; i++) begin
            bus_m0.addr = $urandom; bus_m0.wdata = $urandom; bus_m0.wstrb = 4'($urandom);
            if (i == 3) begin
                bus_s.ready = 1'b1; bus_s.rdata = 32'h0;
            end
            sample();
            n_tests++;
            if (bus_s.valid !== 1'b1 || bus_s.addr !== 32'h1000_0004 || bus_s.wdata !== 32'hA5A5_5A5A || bus_s.wstrb !== 4'b0011) begin
                n_fail++; $display("FAIL write_window[%0d] got v%b a %h d %h s %b want 1 10000004 a5a55a5a 0011",
                                   i, bus_s.valid, bus_s.addr, bus_s.wdata, bus_s.wstrb);
            end
            if (i == 3) begin
                n_tests++;
                if ({bus_m1.ready, bus_m0.ready} !== 2'b10) begin
                    n_fail++; $display("FAIL write_done got m1/m0 ready %b want 10", {bus_m1.ready, bus_m0.ready});
                end
            end
            cyc();
        end
        bus_s.ready = 1'b0; bus_m1.valid = 1'b0;
        sample();
        n_tests++;
        if (bus_s.valid !== 1'b0 || bus_s.wstrb !== 4'b0000 || bus_s.addr !== 32'h1000_0004) begin
            n_fail++; $display("FAIL write_idle got v%b s %b a %h want 0 0000 10000004", bus_s.valid, bus_s.wstrb, bus_s.addr);
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        logic [31:0] a0;
        logic [31:0] rd;
        a0 = $urandom; rd = $urandom;
        idle_bus();
        bus_m1.valid = 1'b1; bus_m1.addr = $urandom; bus_m1.wstrb = 4'h0;
        sample();
        cyc(); sample();
        n_tests++;
        if (bus_s.valid !== 1'b1 || bus_s.addr !== bus_m1.addr) begin
            n_fail++; $display("FAIL rstmid_gnt1 got valid %b addr %h want 1 %h", bus_s.valid, bus_s.addr, bus_m1.addr);
        end
        cyc(); reset = 1'b1; sample();
        cyc(); reset = 1'b0; bus_m0.valid = 1'b1; bus_m0.addr = a0; bus_m0.wstrb = 4'h0; sample();
        n_tests++;
        if ({bus_s.valid, bus_m0.ready, bus_m1.ready, err_flag} !== 4'b0000) begin
            n_fail++; $display("FAIL rstmid_abort got valid/r0/r1/err %b want 0000", {bus_s.valid, bus_m0.ready, bus_m1.ready, err_flag});
        end
        cyc(); sample();
        n_tests++;
        if (bus_s.valid !== 1'b1 || bus_s.addr !== a0) begin
            n_fail++; $display("FAIL rstmid_regrant got valid %b addr %h want 1 %h (m0)", bus_s.valid, bus_s.addr, a0);
        end
        cyc(); bus_s.ready = 1'b1; bus_s.rdata = rd; sample();
        n_tests++;
        if ({bus_m0.ready, bus_m1.ready} !== 2'b10 || bus_m0.rdata !== rd) begin
            n_fail++; $display("FAIL rstmid_done got r0/r1 %b rdata %h want 10 %h", {bus_m0.ready, bus_m1.ready}, bus_m0.rdata, rd);
        end
        cyc(); idle_bus(); sample();
        cyc();
    endtask

`ifdef PERIPH_ARB_WATCHDOG_EN
    localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

    task automatic test_watchdog();
        idle_bus();
        bus_m0.valid = 1'b1; bus_m0.addr = $urandom; bus_m0.wstrb = 4'h0;
        sample();
        for (int g = 1; g <= 8; g++) begin
            cyc(); sample();
            n_tests++;
            if (g < 8) begin
                if ({bus_s.valid, bus_m0.ready} !== 2'b10) begin
                    n_fail++; $display("FAIL wd_wait[%0d] got valid/ready %b want 10", g, {bus_s.valid, bus_m0.ready});
                end
            end else if (bus_m0.ready !== 1'b1 || bus_m0.rdata !== ERR_WORD || err_flag !== 1'b0) begin
                n_fail++; $display("FAIL wd_fire got ready %b rdata %h err %b want 1 deadbeef 0", bus_m0.ready, bus_m0.rdata, err_flag);
            end
        end
        cyc(); bus_m0.valid = 1'b0; sample();
        n_tests++;
        if ({err_flag, err_master, bus_s.valid} !== 3'b100) begin
            n_fail++; $display("FAIL wd_flag_m0 got flag/master/valid %b want 100", {err_flag, err_master, bus_s.valid});
        end
        cyc(); err_clr = 1'b1;
        cyc(); err_clr = 1'b0; sample();
        n_tests++;
        if (err_flag !== 1'b0) begin
            n_fail++; $display("FAIL wd_clear got err_flag %b want 0", err_flag);
        end
        // m1 times out while err_clr is pulsed on the firing cycle
        bus_m1.valid = 1'b1; bus_m1.addr = $urandom; bus_m1.wstrb = 4'h0;
        sample();
        for (int g = 1; g <= 8; g++) begin
            cyc();
            if (g == 8) err_clr = 1'b1;
            sample();
            if (g == 8) begin
                n_tests++;
                if (bus_m1.ready !== 1'b1 || bus_m1.rdata !== ERR_WORD) begin
                    n_fail++; $display("FAIL wd_fire_m1 got ready %b rdata %h want 1 deadbeef", bus_m1.ready, bus_m1.rdata);
                end
            end
        end
        cyc(); err_clr = 1'b0; bus_m1.valid = 1'b0; sample();
        n_tests++;
        if ({err_flag, err_master} !== 2'b11) begin
            n_fail++; $display("FAIL wd_fire_beats_clr got flag/master %b want 11", {err_flag, err_master});
        end
        cyc(); err_clr = 1'b1;
        cyc(); err_clr = 1'b0; sample();
        n_tests++;
        if ({err_flag, err_master} !== 2'b01) begin
            n_fail++; $display("FAIL wd_master_held got flag/master %b want 01", {err_flag, err_master});
        end
        // ready lands exactly on the timeout cycle: normal completion
        bus_m0.valid = 1'b1;
        sample();
        for (int g = 1; g <= 8; g++) begin
            cyc();
            if (g == 8) begin
                bus_s.ready = 1'b1; bus_s.rdata = 32'h1;
            end
            sample();
            if (g == 8) begin
                n_tests++;
                if (bus_m0.ready !== 1'b1 || bus_m0.rdata !== 32'h1) begin
                    n_fail++; $display("FAIL wd_edge_done got ready %b rdata %h want 1 00000001", bus_m0.ready, bus_m0.rdata);
                end
            end
        end
        cyc(); idle_bus(); sample();
        n_tests++;
        if (err_flag !== 1'b0) begin
            n_fail++; $display("FAIL wd_edge_noerr got err_flag %b want 0", err_flag);
        end
        cyc();
    endtask
`else
    task automatic test_no_watchdog();
        logic [31:0] rd;
        rd = $urandom;
        idle_bus();
        bus_m0.valid = 1'b1; bus_m0.addr = $urandom; bus_m0.wstrb = 4'h0;
        sample();
        for (int g = 1; g <= 20; g++) begin
            cyc(); sample();
            n_tests++;
            if ({bus_s.valid, bus_m0.ready, err_flag} !== 3'b100) begin
                n_fail++; $display("FAIL nowd_wait[%0d] got valid/ready/err %b want 100", g, {bus_s.valid, bus_m0.ready, err_flag});
            end
        end
        cyc(); bus_s.ready = 1'b1; bus_s.rdata = rd; sample();
        n_tests++;
        if (bus_m0.ready !== 1'b1 || bus_m0.rdata !== rd) begin
            n_fail++; $display("FAIL nowd_done got ready %b rdata %h want 1 %h", bus_m0.ready, bus_m0.rdata, rd);
        end
        cyc(); idle_bus(); sample();
        n_tests++;
        if ({err_flag, err_master} !== 2'b00) begin
            n_fail++; $display("FAIL nowd_err got %b want 00", {err_flag, err_master});
        end
        cyc();
    endtask
`endif

    // Random masters and slave latency; model tracks who owns the bus
    task automatic test_random();
        int          owner;
        int          last;
        int          gcyc;
        int          wait_lat;
        int          src;
        logic        pend [2];
        logic        got_rdy [2];
        logic [31:0] req_addr [2];
        logic [31:0] req_wdata [2];
        logic [3:0]  req_wstrb [2];
        logic [31:0] deliv [2];
        logic        s_rdy;
        logic [31:0] s_rd;
        logic [1:0]  exp_rdy;
        logic [31:0] exp_rd0;
        logic [31:0] exp_rd1;
        logic        exp_valid;
        owner = -1; last = 1; gcyc = 0; wait_lat = 0;
        for (int m = 0; m < 2; m++) begin
            pend[m] = 1'b0; got_rdy[m] = 1'b0; deliv[m] = 32'h0;
            req_addr[m] = $urandom; req_wdata[m] = $urandom; req_wstrb[m] = 4'($urandom);
        end
        do_reset();
        for (int t = 0; t < 400; t++) begin
            if (t != 0) cyc();
            for (int m = 0; m < 2; m++) begin
                if (got_rdy[m]) pend[m] = 1'b0;
                if (!pend[m] && ($urandom % 10) < 4) begin
                    pend[m] = 1'b1;
                    req_addr[m] = $urandom; req_wdata[m] = $urandom; req_wstrb[m] = 4'($urandom);
                end
            end
            bus_m0.valid = pend[0]; bus_m0.addr = req_addr[0]; bus_m0.wdata = req_wdata[0]; bus_m0.wstrb = req_wstrb[0];
            bus_m1.valid = pend[1]; bus_m1.addr = req_addr[1]; bus_m1.wdata = req_wdata[1]; bus_m1.wstrb = req_wstrb[1];
            s_rdy = (owner >= 0) && (gcyc >= wait_lat);
            s_rd  = $urandom;
            bus_s.ready = s_rdy; bus_s.rdata = s_rd;
            sample();

            exp_valid = (owner >= 0);
            src       = (owner >= 0) ? owner : last;
            exp_rdy   = {(owner == 1) && s_rdy, (owner == 0) && s_rdy};
            exp_rd0   = exp_rdy[0] ? s_rd : deliv[0];
            exp_rd1   = exp_rdy[1] ? s_rd : deliv[1];
            n_tests++;
            if (bus_s.valid !== exp_valid) begin
                n_fail++; $display("FAIL rand_svalid t=%0d got %b want %b", t, bus_s.valid, exp_valid);
            end
            n_tests++;
            if ({bus_s.addr, bus_s.wdata} !== {req_addr[src], req_wdata[src]}) begin
                n_fail++; $display("FAIL rand_sbus t=%0d got %h/%h want %h/%h", t, bus_s.addr, bus_s.wdata, req_addr[src], req_wdata[src]);
            end
            n_tests++;
            if (bus_s.wstrb !== (exp_valid ? req_wstrb[src] : 4'h0)) begin
                n_fail++; $display("FAIL rand_swstrb t=%0d got %b want %b", t, bus_s.wstrb, exp_valid ? req_wstrb[src] : 4'h0);
            end
            n_tests++;
            if ({bus_m1.ready, bus_m0.ready} !== exp_rdy) begin
                n_fail++; $display("FAIL rand_ready t=%0d got %b want %b", t, {bus_m1.ready, bus_m0.ready}, exp_rdy);
            end
            n_tests++;
            if ({bus_m1.rdata, bus_m0.rdata} !== {exp_rd1, exp_rd0}) begin
                n_fail++; $display("FAIL rand_rdata t=%0d got %h/%h want %h/%h", t, bus_m1.rdata, bus_m0.rdata, exp_rd1, exp_rd0);
            end

            got_rdy[0] = exp_rdy[0]; got_rdy[1] = exp_rdy[1];
            if (owner >= 0) begin
                if (s_rdy) begin
                    deliv[owner] = s_rd;
                    owner = -1;
                end else begin
                    gcyc++;
                end
            end else if (pend[0] || pend[1]) begin
                if (pend[0] && pend[1]) owner = 1 - last;
                else                    owner = pend[0] ? 0 : 1;
                last     = owner;
                gcyc     = 0;
                wait_lat = $urandom % 4;
            end
        end
        cyc(); idle_bus();
        cyc(); cyc();
    endtask

    initial begin
        reset = 1'b1;
        idle_bus();
        test_reset();
        test_single_read();
        test_contention();
        test_write_lock();
        test_reset_mid();
`ifdef PERIPH_ARB_WATCHDOG_EN
        test_watchdog();
`else
        test_no_watchdog();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/periph_bus_arbiter.md
Name: periph_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the peripheral register bus; uses the PicoRV32-style valid/ready/addr/wdata/wstrb/rdata handshake.
- Lets the CPU (m0) and a second bus master (m1, debug/DMA engine) share the peripheral block (msec counter, spare register) without corrupting each other's transfers.
- Round-robin grant, locked for the whole transfer, with an optional watchdog that terminates hung transfers.

Parameters:
- TIMEOUT_CYCLES, 255, cycles s_valid may stay high without s_ready before the watchdog fires (range 2..65535).
- ERR_RDATA, 32'hDEAD_BEEF, read data returned to the master on a watchdog termination.

Ports:
- cpu_clk  input  1  single clock for all logic
- reset  input  1  synchronous, active-high reset
- m0_valid  input  1  master 0 request
- m0_addr  input  32  master 0 address
- m0_wdata  input  32  master 0 write data
- m0_wstrb  input  4  master 0 byte strobes (0 = read)
- m0_ready  output  1  master 0 completion pulse
- m0_rdata  output  32  master 0 read data
- m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata: same widths and meaning for master 1
- s_valid  output  1  request to slave
- s_addr  output  32  muxed address
- s_wdata  output  32  muxed write data
- s_wstrb  output  4  muxed strobes
- s_ready  input  1  slave completion
- s_rdata  input  32  slave read data
- err_flag  output  1  sticky watchdog-fired flag
- err_master  output  1  master that was granted when the watchdog last fired
- err_clr  input  1  clears err_flag

Behaviour:
- Clock and reset: one clock, cpu_clk. Reset is synchronous and active-high (reset).
- Reset values:
  - state = IDLE
  - last_grant = 1, so m0 wins the first contention
  - wd_cnt = 0, err_flag = 0, err_master = 0
  - s_valid = 0, m0_ready = 0, m1_ready = 0
- States:
  - IDLE: s_valid = 0.
    - Only m0_valid: go to GNT0.
    - Only m1_valid: go to GNT1.
    - Both valid: grant the master != last_grant.
    - Neither valid: stay in IDLE.
    - On entering GNTx, last_grant <= x and wd_cnt <= 0.
  - GNTx: s_valid = 1. s_addr, s_wdata and s_wstrb are driven combinationally from master x.
    - mx_ready = s_ready and mx_rdata = s_rdata (combinational pass-through).
    - The non-granted master sees ready = 0, and its rdata holds its last delivered value.
    - On s_ready: go to IDLE.
- Latency:
  - Request in cycle N (state IDLE) → s_valid high in cycle N+1.
  - With the existing one-cycle peripheral, ready arrives at N+2.
  - IDLE is forced for ≥1 cycle between transfers, so the slave always sees s_valid low after each ready.
  - Back-to-back throughput is one transfer per 3 cycles.
- Grant lock: the grant never changes while in GNTx.
  - If the granted master drops valid mid-transfer (protocol violation), the slave transfer still completes and mx_ready still pulses.
- Outside GNTx, s_addr/s_wdata/s_wstrb follow master last_grant. s_wstrb is forced to 0 when s_valid = 0.
- m*_rdata are registered captures of the delivered value, updated only on that master's ready cycle. Reset value is 0.
- Reset asserted mid-transfer: next cycle is IDLE with s_valid = 0. No ready pulse is produced for the aborted transfer.
- err_clr and a watchdog firing in the same cycle: the fire wins, and err_flag stays 1.

Optional Feature:
- Macro: PERIPH_ARB_WATCHDOG_EN.
- Defined:
  - In GNTx, wd_cnt increments every cycle that s_ready = 0.
  - When wd_cnt == TIMEOUT_CYCLES-1 and s_ready = 0:
    - mx_ready pulses for one cycle with mx_rdata = ERR_RDATA.
    - err_flag <= 1 and err_master <= x.
    - State goes to IDLE.
  - If s_ready arrives in that same cycle, the normal completion wins and no error is recorded.
  - err_clr = 1 clears err_flag (err_master is held).
- Not defined: no counter is built, GNTx waits indefinitely for s_ready, and err_flag and err_master are tied to 0.

Test Plan:
- Single m0 read, slave returning 32'h0000_1234 with ready one cycle after s_valid: s_valid rises 1 cycle after m0_valid; m0_ready pulses 2 cycles after m0_valid with m0_rdata = 32'h0000_1234; m1_ready stays 0.
- m0 and m1 assert valid in the same cycle after reset, each holding valid until its ready:
  - m0 is served first.
  - One IDLE cycle follows.
  - m1 is served next (s_addr = m1_addr).
  - m0 re-requesting immediately is then served after m1.
  - The grant order alternates 0,1,0,1 over 4 transfers.
- m1 write to addr 32'h...04, wdata 32'hA5A5_5A5A, wstrb 4'b0011: the slave sees exactly those values for the whole s_valid window; m0 changing its address during that window has no effect on s_addr.
- Reset asserted while in GNT1 before s_ready: the next cycle has s_valid = 0, no mx_ready, and err_flag = 0; a subsequent contention is granted to m0.
- With PERIPH_ARB_WATCHDOG_EN defined, TIMEOUT_CYCLES = 8, and a slave that never readies, m0 reads:
  - m0_ready pulses in the 8th GNT0 cycle with m0_rdata = 32'hDEAD_BEEF.
  - err_flag = 1 and err_master = 0.
  - An err_clr pulse returns err_flag to 0.
- Watchdog enabled, slave ready exactly on the timeout cycle with s_rdata = 32'h1: a normal completion with m0_rdata = 32'h1 and err_flag = 0.
